// File: rtl/fwd_prop_seq_if.sv
// Handshake/control bundle between the forward-propagation sequencer and its neighbours.
// The hold signal exists only when FPC_HOLD_EN is defined.
interface fwd_prop_seq_if;
  logic       start;
`ifdef FPC_HOLD_EN
  logic       hold;
`endif
  logic [3:0] ctrl;
  logic [3:0] st;
  logic [3:0] step;
  logic       acc_clr;
  logic       busy;
  logic       done;

  modport master (
`ifdef FPC_HOLD_EN
    output hold,
`endif
    output start,
    input  ctrl, st, step, acc_clr, busy, done
  );

  modport slave (
`ifdef FPC_HOLD_EN
    input  hold,
`endif
    input  start,
    output ctrl, st, step, acc_clr, busy, done
  );
endinterface

// File: rtl/fwd_prop_seq.sv
// Forward-propagation sequencer: CLR -> HID x N_IN -> ACT2 -> OUT -> ACT3 -> LATCH -> DONE.
// Optional stall input enabled by defining FPC_HOLD_EN.
module fwd_prop_seq #(
  parameter int         N_IN    = 9,
  parameter int         ACT_LAT = 1,
  parameter logic [3:0] C_IDLE  = 4'b0000,
  parameter logic [3:0] C_HID   = 4'b0010,
  parameter logic [3:0] C_ACT2  = 4'b0011,
  parameter logic [3:0] C_OUT   = 4'b0100,
  parameter logic [3:0] C_ACT3  = 4'b0101,
  parameter logic [3:0] C_LATCH = 4'b0110
) (
  input  logic         clk,
  input  logic         rst,
  fwd_prop_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_HID, S_ACT2, S_OUT, S_ACT3, S_LATCH, S_DONE
  } state_t;

  localparam logic [3:0] ST_LAST  = 4'(N_IN - 1);
  localparam logic [3:0] ACT_LOAD = 4'(ACT_LAT - 1);

  state_t     state_reg;
  logic [3:0] cnt_reg;
  logic [3:0] st_reg;
  logic [3:0] step_reg;
  logic [3:0] ctrl_reg;
  logic       acc_clr_reg;
  logic       busy_reg;
  logic       done_reg;
  logic       held;

`ifdef FPC_HOLD_EN
  assign held = bus.hold && (state_reg != S_IDLE) && (state_reg != S_DONE);
`else
  assign held = 1'b0;
`endif

  // Outputs are loaded together with the state they belong to, so they are
  // valid for exactly the cycle that state is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= 4'd0;
      st_reg      <= 4'd0;
      step_reg    <= 4'd1;
      ctrl_reg    <= C_IDLE;
      acc_clr_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      ctrl_reg    <= C_IDLE;
      acc_clr_reg <= 1'b0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b1;
      // A held cycle keeps state/st/cnt and emits C_IDLE so nothing accumulates twice.
      if (!held) begin
        case (state_reg)
          S_IDLE: begin
            if (bus.start) begin
              state_reg   <= S_CLR;
              acc_clr_reg <= 1'b1;
              st_reg      <= 4'd0;
            end else begin
              busy_reg <= 1'b0;
            end
          end
          S_CLR: begin
            state_reg <= S_HID;
            ctrl_reg  <= C_HID;
          end
          S_HID: begin
            if (st_reg == ST_LAST) begin
              state_reg <= S_ACT2;
              ctrl_reg  <= C_ACT2;
              cnt_reg   <= ACT_LOAD;
            end else begin
              st_reg   <= st_reg + 4'd1;
              ctrl_reg <= C_HID;
            end
          end
          S_ACT2: begin
            if (cnt_reg == 4'd0) begin
              state_reg <= S_OUT;
              ctrl_reg  <= C_OUT;
            end else begin
              cnt_reg  <= cnt_reg - 4'd1;
              ctrl_reg <= C_ACT2;
            end
          end
          S_OUT: begin
            state_reg <= S_ACT3;
            ctrl_reg  <= C_ACT3;
            cnt_reg   <= ACT_LOAD;
          end
          S_ACT3: begin
            if (cnt_reg == 4'd0) begin
              state_reg <= S_LATCH;
              ctrl_reg  <= C_LATCH;
            end else begin
              cnt_reg  <= cnt_reg - 4'd1;
              ctrl_reg <= C_ACT3;
            end
          end
          S_LATCH: begin
            state_reg <= S_DONE;
            done_reg  <= 1'b1;
          end
          S_DONE: begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
            // step skips 0 because the datapath treats step==0 as invalid
            step_reg  <= (step_reg == 4'd15) ? 4'd1 : step_reg + 4'd1;
          end
          default: begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.ctrl    = ctrl_reg;
  assign bus.st      = st_reg;
  assign bus.step    = step_reg;
  assign bus.acc_clr = acc_clr_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;

endmodule
